instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
// Packs instruction fields (opcode, register ids, immediate nibble) into 16-bit instruction words.
// The word layout is {a[3:0], b[3:0], c[3:0], op[3:0]}.
// Buffers the encoded words in a small FIFO and streams them into instruction memory at consecutive addresses.
// Sits between the program loader / test harness and instruction RAM, so it is the inverse of the instruction decoder.
// PARAMETERS
// DEPTH      4   encoded-word FIFO entries (power of 2, >=2)
// ADDR_W     8   instruction memory address width
// BASE_ADDR  0   first address written after reset/clear
// PORTS
// clk          in   1        clock
// rst          in   1        synchronous active-high reset
// clear        in   1        sync restart: flush FIFO, addr<=BASE_ADDR, clear flags, state<=RUN
// in_valid     in   1        field bundle valid
// in_ready     out  1        encoder can accept a bundle this cycle
// in_op        in   4        opcode (0 noop .. 12 cjump, 13/14 reserved, 15 halt)
// in_a         in   5        register id for field a (decoder form {idx,1'b1}; 0 = unused)
// in_b         in   5        register id for field b (same form)
// in_c         in   4        raw field c (register index or immediate)
// mem_we       out  1        write request to instruction RAM
// mem_ready    in   1        RAM accepts write this cycle
// mem_addr     out  ADDR_W   write address
// mem_wdata    out  16       encoded instruction word
// words_written out ADDR_W+1 count of completed writes since reset/clear
// done         out  1        halt word written; encoder idle
// err_illegal  out  1        sticky: a bundle was rejected as illegal
// err_wrap     out  1        sticky: address wrapped past 2^ADDR_W-1
// BEHAVIOUR
// - Reset (rst=1 at clk edge):
//   - FIFO empty, state RUN, mem_addr=BASE_ADDR.
//   - mem_we=0, words_written=0, done=0, err_illegal=0, err_wrap=0.
//   - in_ready=1 from the first cycle after reset.
//   - rst overrides clear.
// - States:
//   - RUN -> DRAIN when an op=15 bundle is accepted.
//   - DRAIN -> DONE when the halt word write completes.
//   - DONE -> RUN only on clear or rst.
// - in_ready = (state==RUN) && !fifo_full. It is combinational from registered state only, never from in_valid.
// - Accept = in_valid && in_ready. On accept the bundle is legal when all of the following hold:
//   - op not in {13,14};
//   - in_a==0 or in_a[0]==1;
//   - in_b==0 or in_b[0]==1.
// - Legal bundle: word {in_a[4:1], in_b[4:1], in_c, in_op} is pushed into the FIFO at that edge.
// - Illegal bundle: consumed but not pushed; err_illegal<=1 (sticky). State is unchanged, and an illegal op is never treated as halt.
// - mem_we = fifo non-empty; mem_wdata = FIFO head; mem_addr = current address register.
// - Write completes when mem_we && mem_ready. On completion:
//   - pop the FIFO;
//   - addr <= addr+1 (mod 2^ADDR_W); words_written++;
//   - if the old addr was 2^ADDR_W-1, set err_wrap<=1 (sticky).
// - mem_we/mem_addr/mem_wdata hold stable while mem_ready=0.
// - Latency: a word accepted at edge N drives mem_we at the earliest in the cycle after edge N (FIFO registered, no bypass).
// - Simultaneous push and pop in one cycle is allowed; the occupancy is unchanged.
// - Full: in_ready=0 even if a pop happens in that same cycle (no fall-through).
// - done=1 in state DONE only; in DONE, mem_we=0 and in_ready=0.
// - clear mid-operation: pending FIFO words are discarded with no further mem_we, and in_ready=1 the next cycle.
// - words_written saturates at 2^(ADDR_W+1)-1.
// TESTING
// 1. rst, then push {op=1,a=5'b00111,b=5'b01001,c=4'h2}; mem_ready=1 -> next cycle mem_we=1, addr=0, wdata=16'h3421.
// 2. Push 6 words back-to-back with mem_ready=0 -> in_ready drops after 4 accepts. Then mem_ready=1 -> writes at addr 0..3, in_ready returns, words_written ends =6 once the remaining 2 are written.
// 3. Push op=13 and op=4 with in_a=5'b00010 -> both consumed, no write, err_illegal=1, words_written=0.
// 4. Push op=2, then op=15, then hold in_valid -> in_ready=0 after the halt is accepted. Writes land at addr 0,1, done=1, nothing further is written.
// 5. ADDR_W=2, BASE_ADDR=3: write 2 words -> addresses 3 then 0, err_wrap=1 after the first completion.
// 6. Fill the FIFO with mem_ready=0, pulse clear -> mem_we=0 the next cycle, addr=BASE_ADDR, flags 0, in_ready=1.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder: packs field bundles into 16-bit words {a, b, c, op},
// buffers them in a small FIFO and streams them into instruction RAM at
// consecutive addresses, stopping after the halt word has been written.
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_a,
  input  logic [4:0]        in_b,
  input  logic [3:0]        in_c,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W:0]   words_written,
  output logic              done,
  output logic              err_illegal,
  output logic              err_wrap
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned WcW  = ADDR_W + 1;

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [15:0]       fifo_mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WcW-1:0]    wcount_q;
  logic              err_illegal_q, err_wrap_q;

  logic        fifo_full, fifo_empty;
  logic        accept, legal, push, pop, is_halt;
  logic [15:0] word;

  // Handshake decode, legality check and word packing
  always_comb begin
    fifo_full  = (count_q == CntW'(DEPTH));
    fifo_empty = (count_q == '0);
    // Ready depends on registered state only, never on in_valid
    in_ready   = (state_q == StRun) && !fifo_full;
    accept     = in_valid && in_ready;
    // Register ids arrive in decoder form {idx, 1'b1}; zero means unused
    legal      = (in_op != 4'd13) && (in_op != 4'd14) &&
                 ((in_a == 5'd0) || in_a[0]) &&
                 ((in_b == 5'd0) || in_b[0]);
    push       = accept && legal;
    is_halt    = (in_op == 4'd15);
    word       = {in_a[4:1], in_b[4:1], in_c, in_op};
    mem_we     = !fifo_empty && (state_q != StDone);
    pop        = mem_we && mem_ready;
    mem_wdata  = fifo_mem[rd_ptr_q];
    mem_addr   = addr_q;
    words_written = wcount_q;
    done          = (state_q == StDone);
    err_illegal   = err_illegal_q;
    err_wrap      = err_wrap_q;
  end

  // Next-state logic: halt acceptance starts draining, last pop finishes
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (push && is_halt) state_d = StDrain;
      // No pushes happen while draining, so the halt word is the last entry
      StDrain: if (pop && (count_q == CntW'(1))) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StRun;
    endcase
  end

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= word;
  end

  // Control state, pointers, address and status registers
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q       <= StRun;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      addr_q        <= ADDR_W'(BASE_ADDR);
      wcount_q      <= '0;
      err_illegal_q <= 1'b0;
      err_wrap_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (!push && pop) count_q <= count_q - CntW'(1);
      if (accept && !legal) err_illegal_q <= 1'b1;
      if (pop) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (addr_q == '1) err_wrap_q <= 1'b1;
        if (wcount_q != '1) wcount_q <= wcount_q + WcW'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// traffic compared cycle by cycle against a queue-based reference model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, in_ready, mem_we, mem_ready;
  logic [3:0]  in_op, in_c;
  logic [4:0]  in_a, in_b;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [8:0]  words_written;
  logic        done, err_illegal, err_wrap;

  // Narrow-address instance for wrap-around checks
  logic        w_rst, w_clear, w_valid, w_ready, w_we, w_mready;
  logic [3:0]  w_op, w_c;
  logic [4:0]  w_a, w_b;
  logic [1:0]  w_addr;
  logic [15:0] w_wdata;
  logic [2:0]  w_ww;
  logic        w_done, w_ill, w_wrap;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [15:0] m_q[$];
  int          m_addr, m_ww;
  bit          m_done, m_drain, m_ill, m_wrap, m_acc;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_c(in_c), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .words_written(words_written), .done(done), .err_illegal(err_illegal),
    .err_wrap(err_wrap)
  );

  instr_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(3)) dut_w (
    .clk(clk), .rst(w_rst), .clear(w_clear), .in_valid(w_valid), .in_ready(w_ready),
    .in_op(w_op), .in_a(w_a), .in_b(w_b), .in_c(w_c), .mem_we(w_we),
    .mem_ready(w_mready), .mem_addr(w_addr), .mem_wdata(w_wdata),
    .words_written(w_ww), .done(w_done), .err_illegal(w_ill), .err_wrap(w_wrap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [4:0] a,
                                      input logic [4:0] b, input logic [3:0] c);
    return {a[4:1], b[4:1], c, op};
  endfunction

  // Apply the current inputs to the model for the coming clock edge
  task automatic model_step();
    bit rdy, legal;
    logic [15:0] tmp;
    m_acc = 1'b0;
    if (rst || clear) begin
      m_q.delete();
      m_addr = 0; m_ww = 0;
      m_done = 0; m_drain = 0; m_ill = 0; m_wrap = 0;
    end else begin
      rdy = !m_done && !m_drain && (m_q.size() < 4);
      if (m_q.size() > 0 && !m_done && mem_ready) begin
        tmp = m_q.pop_front();
        if (m_addr == 255) m_wrap = 1;
        m_addr = (m_addr + 1) % 256;
        if (m_ww < 511) m_ww++;
        if (m_drain && m_q.size() == 0) begin
          m_done = 1; m_drain = 0;
        end
      end
      m_acc = in_valid && rdy;
      if (m_acc) begin
        legal = (in_op != 13) && (in_op != 14) && (in_a == 0 || in_a[0]) &&
                (in_b == 0 || in_b[0]);
        if (legal) begin
          m_q.push_back(enc(in_op, in_a, in_b, in_c));
          if (in_op == 15) m_drain = 1;
        end else begin
          m_ill = 1;
        end
      end
    end
  endtask

  task automatic compare();
    bit exp_we;
    exp_we = (m_q.size() > 0) && !m_done;
    check("in_ready", in_ready, !m_done && !m_drain && (m_q.size() < 4));
    check("mem_we", mem_we, exp_we);
    check("mem_addr", mem_addr, m_addr);
    if (exp_we) check("mem_wdata", mem_wdata, m_q[0]);
    check("words_written", words_written, m_ww);
    check("done", done, m_done);
    check("err_illegal", err_illegal, m_ill);
    check("err_wrap", err_wrap, m_wrap);
  endtask

  // One clock: model update, edge, then compare at the falling edge
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic set_in(input logic v, input logic [3:0] op, input logic [4:0] a,
                        input logic [4:0] b, input logic [3:0] c);
    in_valid = v; in_op = op; in_a = a; in_b = b; in_c = c;
  endtask

  task automatic do_reset();
    rst = 1; clear = 0; set_in(0, 0, 0, 0, 0);
    step();
    rst = 0;
  endtask

  // Present a bundle until the model reports acceptance (bounded)
  task automatic push_hold(input logic [3:0] op, input logic [4:0] a,
                           input logic [4:0] b, input logic [3:0] c);
    bit got;
    got = 0;
    set_in(1, op, a, b, c);
    for (int k = 0; k < 12 && !got; k++) begin
      step();
      got = m_acc;
    end
    if (!got) check("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  initial begin
    rst = 1; clear = 0; mem_ready = 0; set_in(0, 0, 0, 0, 0);
    w_rst = 1; w_clear = 0; w_valid = 0; w_op = 0; w_a = 0; w_b = 0; w_c = 0;
    w_mready = 0;
    @(negedge clk);

    // Wrap-around on the 2-bit address instance, base address 3
    @(posedge clk); @(negedge clk);
    w_rst = 0;
    check("w_reset_addr", w_addr, 3);
    check("w_reset_ready", w_ready, 1);
    check("w_reset_we", w_we, 0);
    w_valid = 1; w_op = 4'd1; w_mready = 1;
    @(posedge clk); @(negedge clk);
    check("w_first_we", w_we, 1);
    check("w_first_addr", w_addr, 3);
    check("w_first_wrap", w_wrap, 0);
    w_op = 4'd2;
    @(posedge clk); @(negedge clk);
    w_valid = 0;
    check("w_second_addr", w_addr, 0);
    check("w_second_wdata", w_wdata, 16'h0002);
    check("w_wrap_set", w_wrap, 1);
    @(posedge clk); @(negedge clk);
    check("w_ww", w_ww, 2);
    check("w_idle_we", w_we, 0);

    // Reset state and single word
    do_reset();
    check("reset_ready", in_ready, 1);
    check("reset_addr", mem_addr, 0);
    mem_ready = 1;
    set_in(1, 4'd1, 5'b00111, 5'b01001, 4'h2);
    step();
    in_valid = 0;
    check("t1_we", mem_we, 1);
    check("t1_addr", mem_addr, 0);
    check("t1_wdata", mem_wdata, 16'h3421);
    step();
    check("t1_ww", words_written, 1);

    // Back-pressure: FIFO fills after four accepts
    do_reset();
    mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      set_in(1, 4'(i + 1), 5'(2 * i + 1), 5'b00011, 4'(i));
      step();
    end
    check("t2_full_ready", in_ready, 0);
    mem_ready = 1;
    push_hold(4'd5, 5'b11111, 5'b00000, 4'h9);
    push_hold(4'd6, 5'b10101, 5'b01011, 4'hc);
    for (int k = 0; k < 10 && m_q.size() > 0; k++) step();
    step();
    check("t2_ww", words_written, 6);
    check("t2_addr", mem_addr, 6);

    // Illegal bundles are consumed without writes
    do_reset();
    mem_ready = 1;
    set_in(1, 4'd13, 0, 0, 0);
    step();
    set_in(1, 4'd4, 5'b00010, 0, 0);
    step();
    in_valid = 0;
    step();
    check("t3_ill", err_illegal, 1);
    check("t3_ww", words_written, 0);
    check("t3_we", mem_we, 0);

    // Halt terminates the stream
    do_reset();
    mem_ready = 1;
    set_in(1, 4'd2, 0, 0, 0);
    step();
    set_in(1, 4'd15, 0, 0, 0);
    step();
    set_in(1, 4'd3, 0, 0, 0);
    for (int k = 0; k < 4; k++) step();
    in_valid = 0;
    check("t4_ready", in_ready, 0);
    check("t4_done", done, 1);
    check("t4_ww", words_written, 2);
    check("t4_addr", mem_addr, 2);
    check("t4_we", mem_we, 0);

    // Clear discards pending words and sticky flags
    do_reset();
    mem_ready = 0;
    set_in(1, 4'd14, 0, 0, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 4'd7, 5'b00101, 5'b00001, 4'(i));
      step();
    end
    set_in(0, 0, 0, 0, 0);
    clear = 1;
    step();
    clear = 0;
    check("t6_we", mem_we, 0);
    check("t6_addr", mem_addr, 0);
    check("t6_ill", err_illegal, 0);
    check("t6_ready", in_ready, 1);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      clear     = ($urandom_range(0, 39) == 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      set_in($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             4'($urandom_range(0, 15)));
      if (in_op == 4'd15 && $urandom_range(0, 3) != 0) in_op = 4'd1;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
